fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the pipelined CPU; replaces the single-path MEM-to-EX operand mux.
- Owns a shadow tag pipeline (EX, MEM, WB) of destination register, RegWrite and MemRead, advanced by the unit itself.
- Each cycle it selects EX-stage operand data from EX/MEM, MEM/WB or the register-read value for NUM_SRC source operands.
- Detects load-use hazards in ID, inserts a one-cycle bubble, honours branch flush, and keeps a stall performance counter.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fwd_operand_sel.sv | 52 +++++
 rtl/fwd_hazard_unit.sv | 123 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, tag field sizes and operand-forwarding
// select encodings for the pipelined CPU.
package cpu_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int REG_AW_DEF  = 4;
  localparam int NUM_SRC_DEF = 2;
  localparam int CNT_W_DEF   = 16;

  localparam int FWD_SEL_W = 2;
  typedef logic [FWD_SEL_W-1:0] fwdSel_t;

  localparam fwdSel_t FWD_RF  = 2'b00;
  localparam fwdSel_t FWD_WB  = 2'b01;
  localparam fwdSel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: picks one EX operand from EX/MEM, MEM/WB or the
// register-file read value, youngest producer first.
module fwd_operand_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              srcUsed,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] memDst,
  input  logic              wbValid,
  input  logic              wbRegWrite,
  input  logic [REG_AW-1:0] wbDst,
  input  logic [DATA_W-1:0] regData,
  input  logic [DATA_W-1:0] memData,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] opData,
  output fwdSel_t           fwdSel
);

  logic memHit;
  logic wbHit;

  assign memHit = memValid & memRegWrite & srcUsed
                & (memDst == src)
                & (!ZERO_REG | (memDst != '0));

  assign wbHit = wbValid & wbRegWrite & srcUsed
               & (wbDst == src)
               & (!ZERO_REG | (wbDst != '0));

  always_comb begin
    opData = regData;
    fwdSel = FWD_RF;
    priority case (1'b1)
      memHit: begin
        opData = memData;
        fwdSel = FWD_MEM;
      end
      wbHit: begin
        opData = wbData;
        fwdSel = FWD_WB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow tag pipeline, per-operand forwarding,
// load-use stall with flush override and a saturating stall counter.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
  input  logic [NUM_SRC*DATA_W-1:0] ex_src_data,
  input  logic [DATA_W-1:0]         mem_result,
  input  logic [DATA_W-1:0]         wb_result,
  output logic [NUM_SRC*DATA_W-1:0] ex_op_data,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_count
);

  typedef struct packed {
    logic                      valid;
    logic [REG_AW-1:0]         dst;
    logic                      regWrite;
    logic                      memRead;
    logic [NUM_SRC*REG_AW-1:0] src;
    logic [NUM_SRC-1:0]        srcUsed;
  } exTag_t;

  // Past EX only the destination matters; a load in MEM can
  // never be a forwarding source because of the stall.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regWrite;
  } wrTag_t;

  exTag_t exTag;
  wrTag_t memTag;
  wrTag_t wbTag;
  logic   depHit;
  logic   exDstLive;
  logic   exLoad;

  assign exLoad = id_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      exTag  <= '0;
      memTag <= '0;
      wbTag  <= '0;
    end else begin
      if (exLoad) begin
        exTag.valid    <= 1'b1;
        exTag.dst      <= id_dst;
        exTag.regWrite <= id_regwrite;
        exTag.memRead  <= id_memread;
        exTag.src      <= id_src;
        exTag.srcUsed  <= id_src_used;
      end else begin
        exTag <= '0;
      end
      memTag.valid    <= exTag.valid;
      memTag.dst      <= exTag.dst;
      memTag.regWrite <= exTag.regWrite;
      wbTag           <= memTag;
    end
  end

  always_comb begin
    depHit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] &&
          id_src[i*REG_AW +: REG_AW] == exTag.dst)
        depHit = 1'b1;
    end
  end

  assign exDstLive = !ZERO_REG || (exTag.dst != '0);

  assign stall = id_valid & ~flush & exTag.valid
               & exTag.regWrite & exTag.memRead
               & exDstLive & depHit;

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (stall && stall_count != '1)
      stall_count <= stall_count + CNT_W'(1);
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : gOp
    fwd_operand_sel #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .ZERO_REG(ZERO_REG)
    ) uSel (
      .src        (exTag.src[i*REG_AW +: REG_AW]),
      .srcUsed    (exTag.srcUsed[i]),
      .memValid   (memTag.valid),
      .memRegWrite(memTag.regWrite),
      .memDst     (memTag.dst),
      .wbValid    (wbTag.valid),
      .wbRegWrite (wbTag.regWrite),
      .wbDst      (wbTag.dst),
      .regData    (ex_src_data[i*DATA_W +: DATA_W]),
      .memData    (mem_result),
      .wbData     (wb_result),
      .opData     (ex_op_data[i*DATA_W +: DATA_W]),
      .fwdSel     (fwd_sel[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vector table, hand sequences and random
// traffic checked against an instruction-level pipeline model.
module tb_fwd_hazard_unit;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NS = 2;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]    id_src_used;
  logic [AW-1:0]    id_dst;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic [NS*DW-1:0] ex_src_data;
  logic [DW-1:0]    mem_result;
  logic [DW-1:0]    wb_result;
  logic [NS*DW-1:0] ex_op_data;
  logic [2*NS-1:0]  fwd_sel;
  logic             stall;
  logic [CW-1:0]    stall_count;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .DATA_W  (DW),
    .REG_AW  (AW),
    .NUM_SRC (NS),
    .ZERO_REG(1'b1),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_src     (id_src),
    .id_src_used(id_src_used),
    .id_dst     (id_dst),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .flush      (flush),
    .ex_src_data(ex_src_data),
    .mem_result (mem_result),
    .wb_result  (wb_result),
    .ex_op_data (ex_op_data),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .stall_count(stall_count)
  );

  typedef struct {
    bit        rst, idv, fl;
    bit [3:0]  s0, s1;
    bit [1:0]  used;
    bit [3:0]  dst;
    bit        rw, ld;
    bit [15:0] memR, wbR, rd0, rd1;
    bit        chk, eSt;
    bit [3:0]  eSel;
    bit [15:0] e0, e1;
    bit [3:0]  eCnt;
  } vec_t;

  typedef struct packed {
    bit       v;
    bit [3:0] dst;
    bit       rw, ld;
    bit [3:0] s0, s1;
    bit [1:0] used;
  } ins_t;

  int   nChecks = 0;
  int   nErrors = 0;
  ins_t mEx, mMem, mWb;
  int   mCnt = 0;
  bit   mInit = 1'b0;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t op(bit r, bit iv, bit f, bit [3:0] s0,
                              bit [3:0] s1, bit [1:0] u, bit [3:0] d,
                              bit rw, bit ld);
    vec_t v;
    v = '{default: 0};
    v.rst = r; v.idv = iv; v.fl = f;
    v.s0 = s0; v.s1 = s1; v.used = u;
    v.dst = d; v.rw = rw; v.ld = ld;
    v.memR = 16'h1234; v.wbR = 16'hBEEF;
    v.rd0 = 16'hAAAA; v.rd1 = 16'h5555;
    return v;
  endfunction

  function automatic vec_t dat(vec_t v, bit [15:0] m, bit [15:0] w);
    v.memR = m; v.wbR = w;
    return v;
  endfunction

  function automatic vec_t want(vec_t v, bit st, bit [3:0] sel,
                                bit [15:0] e0, bit [15:0] e1,
                                bit [3:0] cnt);
    v.chk = 1'b1; v.eSt = st; v.eSel = sel;
    v.e0 = e0; v.e1 = e1; v.eCnt = cnt;
    return v;
  endfunction

  // Does an older instruction p supply register r to a reader?
  function automatic bit wr(ins_t p, bit [3:0] r, bit u);
    return u && p.v && p.rw && p.dst == r && r != 0;
  endfunction

  task automatic step(input vec_t v);
    ins_t      idI;
    bit        eSt;
    bit [3:0]  eSel;
    bit [15:0] eOp [2];
    bit [3:0]  src;
    @(negedge clk);
    rst = v.rst; id_valid = v.idv; flush = v.fl;
    id_src = {v.s1, v.s0}; id_src_used = v.used;
    id_dst = v.dst; id_regwrite = v.rw; id_memread = v.ld;
    ex_src_data = {v.rd1, v.rd0};
    mem_result = v.memR; wb_result = v.wbR;
    #1;
    idI = '{v: v.idv, dst: v.dst, rw: v.rw, ld: v.ld,
            s0: v.s0, s1: v.s1, used: v.used};
    eSt = v.idv && !v.fl && mEx.v && mEx.rw && mEx.ld
       && mEx.dst != 0
       && ((v.used[0] && v.s0 == mEx.dst) ||
           (v.used[1] && v.s1 == mEx.dst));
    eSel = '0;
    for (int i = 0; i < 2; i++) begin
      src = (i == 1) ? mEx.s1 : mEx.s0;
      if (wr(mMem, src, mEx.used[i])) begin
        eSel[2*i +: 2] = 2'b10; eOp[i] = v.memR;
      end else if (wr(mWb, src, mEx.used[i])) begin
        eSel[2*i +: 2] = 2'b01; eOp[i] = v.wbR;
      end else begin
        eOp[i] = (i == 1) ? v.rd1 : v.rd0;
      end
    end
    if (mInit) begin
      chk("model.stall", stall, eSt);
      chk("model.fwdSel", fwd_sel, eSel);
      chk("model.op0", ex_op_data[15:0], eOp[0]);
      chk("model.op1", ex_op_data[31:16], eOp[1]);
      chk("model.count", stall_count, mCnt);
      for (int i = 0; i < 2; i++)
        if (fwd_sel[2*i +: 2] == 2'b10)
          chk("memLoadFwd", mMem.ld, 0);
    end
    if (v.chk) begin
      chk("tbl.stall", stall, v.eSt);
      chk("tbl.fwdSel", fwd_sel, v.eSel);
      chk("tbl.op0", ex_op_data[15:0], v.e0);
      chk("tbl.op1", ex_op_data[31:16], v.e1);
      chk("tbl.count", stall_count, v.eCnt);
    end
    @(posedge clk);
    if (v.rst) begin
      mEx = '0; mMem = '0; mWb = '0; mCnt = 0; mInit = 1'b1;
    end else begin
      if (eSt && mCnt < 15) mCnt++;
      mWb = mMem;
      mMem = mEx;
      mEx = (v.idv && !eSt && !v.fl) ? idI : '0;
    end
  endtask

  initial begin
    vec_t v;
    vec_t nop;
    vec_t ld6;
    vec_t use6;
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    id_src = '0; id_src_used = '0; id_dst = '0;
    id_regwrite = 1'b0; id_memread = 1'b0;
    ex_src_data = '0; mem_result = '0; wb_result = '0;
    mEx = '0; mMem = '0; mWb = '0;

    nop = op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ld6 = op(0, 1, 0, 1, 2, 0, 6, 1, 1);
    use6 = op(0, 1, 0, 6, 6, 2'b11, 7, 1, 0);

    vecs.push_back(op(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(op(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(want(nop, 0, 4'b0000, 16'hAAAA, 16'h5555, 0));
    // EX/MEM forward
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 3, 1, 0));
    vecs.push_back(op(0, 1, 0, 3, 5, 2'b11, 4, 1, 0));
    vecs.push_back(want(nop, 0, 4'b0010, 16'h1234, 16'h5555, 0));
    // MEM/WB forward on operand 1
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 3, 1, 0));
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 8, 1, 0));
    vecs.push_back(op(0, 1, 0, 9, 3, 2'b11, 10, 1, 0));
    vecs.push_back(want(nop, 0, 4'b0100, 16'hAAAA, 16'hBEEF, 0));
    // r3 in both MEM and WB: youngest wins
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 3, 1, 0));
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 3, 1, 0));
    vecs.push_back(op(0, 1, 0, 3, 3, 2'b11, 11, 1, 0));
    vecs.push_back(want(dat(nop, 16'h0001, 16'h0002), 0, 4'b1010,
                        16'h0001, 16'h0001, 0));
    // load-use: one stall, then WB forward
    vecs.push_back(ld6);
    vecs.push_back(want(use6, 1, 4'b0000, 16'hAAAA, 16'h5555, 0));
    vecs.push_back(want(use6, 0, 4'b0000, 16'hAAAA, 16'h5555, 1));
    vecs.push_back(want(dat(nop, 16'h1234, 16'hCAFE), 0, 4'b0101,
                        16'hCAFE, 16'hCAFE, 1));
    // flush beats stall
    vecs.push_back(ld6);
    vecs.push_back(want(op(0, 1, 1, 6, 6, 2'b11, 7, 1, 0), 0, 4'b0000,
                        16'hAAAA, 16'h5555, 1));
    vecs.push_back(want(nop, 0, 4'b0000, 16'hAAAA, 16'h5555, 1));
    // r0 never forwards or stalls
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 0, 1, 0));
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 0, 1, 1));
    vecs.push_back(want(op(0, 1, 0, 0, 0, 2'b11, 12, 1, 0), 0, 4'b0000,
                        16'hAAAA, 16'h5555, 1));
    vecs.push_back(want(nop, 0, 4'b0000, 16'hAAAA, 16'h5555, 1));
    // reset during a stall
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 5, 1, 1));
    vecs.push_back(want(op(1, 1, 0, 5, 2, 2'b01, 13, 1, 0), 1, 4'b0000,
                        16'hAAAA, 16'h5555, 1));
    vecs.push_back(want(op(0, 1, 0, 5, 2, 2'b01, 13, 1, 0), 0, 4'b0000,
                        16'hAAAA, 16'h5555, 0));
    // back-to-back loads into one consumer
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 6, 1, 1));
    vecs.push_back(op(0, 1, 0, 1, 2, 0, 7, 1, 1));
    vecs.push_back(op(0, 1, 0, 6, 7, 2'b11, 8, 1, 0));
    vecs.push_back(op(0, 1, 0, 6, 7, 2'b11, 8, 1, 0));
    vecs.push_back(want(nop, 0, 4'b0100, 16'hAAAA, 16'hBEEF, 1));
    vecs.push_back(want(nop, 0, 4'b0000, 16'hAAAA, 16'h5555, 1));
    // saturation of the 4-bit counter
    for (int k = 0; k < 18; k++) begin
      vecs.push_back(ld6);
      vecs.push_back(op(0, 1, 0, 6, 1, 2'b01, 7, 1, 0));
      vecs.push_back(op(0, 1, 0, 6, 1, 2'b01, 7, 1, 0));
    end
    vecs.push_back(nop);
    vecs.push_back(want(nop, 0, 4'b0000, 16'hAAAA, 16'h5555, 4'hF));

    foreach (vecs[k]) step(vecs[k]);

    for (int k = 0; k < 400; k++) begin
      v = op($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 7) == 0,
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      v.memR = 16'($urandom); v.wbR = 16'($urandom);
      v.rd0 = 16'($urandom); v.rd1 = 16'($urandom);
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
